mode_seq_counter: RTL and testbench
===================================

MODE_SEQ_COUNTER -- requirements
Module: mode_seq_counter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the counter width in bits; legal values are N >= 2.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port enable, input, 1 bit: advance one step per clock when high.
REQ-005 SHALL have port clr, input, 1 bit: synchronous clear to the seed of the current mode.
REQ-006 SHALL have port load, input, 1 bit: synchronous load of load_val.
REQ-007 SHALL have port load_val, input, N bits: value to load.
REQ-008 SHALL have port dir, input, 1 bit: step direction, 0 = up/left, 1 = down/right.
REQ-009 SHALL have port mode, input, 2 bits: 00 binary, 01 gray, 10 johnson, 11 ring.
REQ-010 SHALL have port limit, input, N bits: wrap limit, used in binary and gray modes only.
REQ-011 SHALL have port sat, input, 1 bit: 1 = saturate, 0 = wrap; used in binary and gray modes only.
REQ-012 SHALL have port count, output, N bits: registered sequence value.
REQ-013 SHALL have port tc, output, 1 bit: registered terminal-count pulse.

Function
REQ-014 SHALL keep one N-bit state register st and a registered copy mode_q of the last applied mode.
REQ-015 SHALL drive count as follows: st in binary, johnson and ring modes; gray(st) = st ^ (st >> 1) in gray mode.
REQ-016 SHALL use these seeds: 0 for binary, gray and johnson; 1 (LSB set) for ring.
REQ-017 SHALL apply per-edge priority clr > load > mode change (mode != mode_q) > enable > hold.
REQ-018 SHALL respond to clr by setting st to the seed of mode, setting mode_q to mode and setting tc to 0.
REQ-019 SHALL respond to load by setting st to load_val unmodified, even if the value is not one-hot or not a Johnson code, setting mode_q to mode and setting tc to 0.
REQ-020 SHALL respond to a mode change by setting st to the new seed and mode_q to mode, regardless of enable, with tc 0.
REQ-021 SHALL step binary and gray modes up as follows: if st >= limit, next st is 0 (sat=0) or st holds (sat=1), and tc is 1; otherwise st+1 and tc is 0.
REQ-022 SHALL step binary and gray modes down as follows: if st == 0, next st is limit (sat=0) or 0 holds (sat=1), and tc is 1; otherwise st-1 and tc is 0.
REQ-023 SHALL treat limit == 0 as follows: st stays 0 and tc is 1 on every enabled cycle.
REQ-024 SHALL step johnson mode as follows: dir=0 gives st = {st[N-2:0], ~st[N-1]}; dir=1 gives st = {~st[0], st[N-1:1]}; tc is 1 when the next st is 0.
REQ-025 SHALL step ring mode as follows: dir=0 rotates left, dir=1 rotates right; tc is 1 when the next st equals 1.
REQ-026 SHALL ignore limit and sat in johnson and ring modes.
REQ-027 SHALL hold st and set tc to 0 when enable=0 and no higher-priority event occurs.
REQ-028 SHALL make tc a single-cycle pulse aligned with the count value produced by the same edge; it is never combinational.
REQ-029 SHALL sample a change of limit or dir on the next edge only, with no extra latency.
REQ-030 SHALL make all arithmetic modulo 2^N with no overflow flag.

Reset
REQ-031 SHALL, while rst is high, force st=0, mode_q=00, count=0 and tc=0 asynchronously.
REQ-032 SHALL, after rst deasserts, load the new seed via the mode-change rule on the first edge if mode != 00.
REQ-033 SHALL abandon any operation in progress on reset mid-operation, with no memory of the prior state.

Structure
REQ-034 SHALL place the mode encodings (MODE_BIN, MODE_GRAY, MODE_JOHNSON, MODE_RING) and the seed constants in shared package seq_counter_pkg.
REQ-035 SHALL implement the binary-to-gray conversion as combinational sub-module gray_encode, parameterised by N.
REQ-036 SHALL implement the next-state logic as one combinational block feeding a single registered process.

Verification
REQ-037 SHALL cover: N=4, binary, up, limit=9, sat=0, enable held for 12 cycles -> count 1..9,0,1,2 with tc=1 only with count=0.
REQ-038 SHALL cover: binary, down, limit=5, sat=1, starting at st=1, enable for 4 cycles -> count 0,0,0,0 with tc 0,1,1,1.
REQ-039 SHALL cover: gray, up, limit=15, 16 enabled cycles from reset -> count 1,3,2,6,...,8,0 with exactly one bit changing per step and tc with the final 0.
REQ-040 SHALL cover: johnson, dir=0, 8 enabled cycles -> count 1,3,7,F,E,C,8,0 with tc with the final 0; then dir=1 for 1 cycle -> count 8.
REQ-041 SHALL cover: ring, mode switched from binary at count=7 -> count=1 the next cycle with enable=0; then 4 left steps -> 2,4,8,1 with tc with the final 1.
REQ-042 SHALL cover: load=1 and clr=1 together with load_val=A -> count = seed; rst asserted mid-count (count=6) -> count=0 immediately, before the next edge.

Source files
------------

// File: rtl/seq_counter_pkg.sv
// Shared mode encodings and seed constants for the multi-mode sequence counter.
// Seeds are width-independent and get resized by the counter that uses them.
package seq_counter_pkg;

    typedef enum logic [1:0] {
        MODE_BIN     = 2'b00,
        MODE_GRAY    = 2'b01,
        MODE_JOHNSON = 2'b10,
        MODE_RING    = 2'b11
    } mode_e;

    localparam int SEED_BIN     = 0;
    localparam int SEED_GRAY    = 0;
    localparam int SEED_JOHNSON = 0;
    localparam int SEED_RING    = 1;

    function automatic int seed_of(input mode_e m);
        case (m)
            MODE_GRAY:    return SEED_GRAY;
            MODE_JOHNSON: return SEED_JOHNSON;
            MODE_RING:    return SEED_RING;
            default:      return SEED_BIN;
        endcase
    endfunction

endpackage

// File: rtl/gray_encode.sv
// Combinational binary-to-reflected-Gray conversion.
module gray_encode #(
    parameter int N = 4
) (
    input  logic [N-1:0] bin,
    output logic [N-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/mode_seq_counter.sv
// Multi-mode sequence counter: binary, Gray, Johnson and ring sequences with
// limit/saturate control in the arithmetic modes and a registered terminal-count pulse.
module mode_seq_counter
    import seq_counter_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         enable,
    input  logic         clr,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         dir,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    input  logic         sat,
    output logic [N-1:0] count,
    output logic         tc
);

    mode_e        mode_in;
    mode_e        mode_q, mode_d;
    logic [N-1:0] st_q, st_d;
    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic [N-1:0] step_st;
    logic         step_tc;
    logic [N-1:0] gray_d;

    assign mode_in = mode_e'(mode);

    // Step result for the currently applied mode; only used when enable wins priority.
    always_comb begin
        step_st = st_q;
        step_tc = 1'b0;
        case (mode_q)
            MODE_BIN, MODE_GRAY: begin
                if (!dir) begin
                    if (st_q >= limit) begin
                        step_st = sat ? st_q : '0;
                        step_tc = 1'b1;
                    end else begin
                        step_st = st_q + N'(1);
                    end
                end else begin
                    if (st_q == '0) begin
                        step_st = sat ? '0 : limit;
                        step_tc = 1'b1;
                    end else begin
                        step_st = st_q - N'(1);
                    end
                end
            end
            MODE_JOHNSON: begin
                step_st = dir ? {~st_q[0], st_q[N-1:1]} : {st_q[N-2:0], ~st_q[N-1]};
                step_tc = (step_st == '0);
            end
            default: begin
                step_st = dir ? {st_q[0], st_q[N-1:1]} : {st_q[N-2:0], st_q[N-1]};
                step_tc = (step_st == N'(1));
            end
        endcase
    end

    always_comb begin
        st_d   = st_q;
        mode_d = mode_q;
        tc_d   = 1'b0;
        if (clr) begin
            st_d   = N'(seed_of(mode_in));
            mode_d = mode_in;
        end else if (load) begin
            st_d   = load_val;
            mode_d = mode_in;
        end else if (mode_in != mode_q) begin
            st_d   = N'(seed_of(mode_in));
            mode_d = mode_in;
        end else if (enable) begin
            st_d = step_st;
            tc_d = step_tc;
        end
    end

    gray_encode #(.N(N)) u_gray_encode (
        .bin  (st_d),
        .gray (gray_d)
    );

    // count is registered from the next state so it lands on the same edge as tc.
    assign count_d = (mode_d == MODE_GRAY) ? gray_d : st_d;

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= '0;
            mode_q  <= MODE_BIN;
            count_q <= '0;
            tc_q    <= 1'b0;
        end else begin
            st_q    <= st_d;
            mode_q  <= mode_d;
            count_q <= count_d;
            tc_q    <= tc_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;

endmodule

// File: tb/tb_mode_seq_counter.sv
// Directed, table-driven bench for mode_seq_counter (N=4) plus hand-written
// sequences for asynchronous reset mid-count and the post-reset mode change.
module tb_mode_seq_counter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         enable;
    logic         clr;
    logic         load;
    logic [N-1:0] load_val;
    logic         dir;
    logic [1:0]   mode;
    logic [N-1:0] limit;
    logic         sat;
    logic [N-1:0] count;
    logic         tc;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic         clr;
        logic         load;
        logic [N-1:0] load_val;
        logic         enable;
        logic         dir;
        logic [1:0]   mode;
        logic [N-1:0] limit;
        logic         sat;
        logic [N-1:0] exp_count;
        logic         exp_tc;
        string        tag;
    } vec_t;

    vec_t vecs[$];

    mode_seq_counter #(.N(N)) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .dir      (dir),
        .mode     (mode),
        .limit    (limit),
        .sat      (sat),
        .count    (count),
        .tc       (tc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input string tag, input logic c, input logic l, input logic [N-1:0] lv,
                       input logic en, input logic d, input logic [1:0] m,
                       input logic [N-1:0] lim, input logic s,
                       input logic [N-1:0] ec, input logic et);
        vec_t v;
        v.clr = c; v.load = l; v.load_val = lv; v.enable = en; v.dir = d;
        v.mode = m; v.limit = lim; v.sat = s; v.exp_count = ec; v.exp_tc = et;
        v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        enable = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0;
        dir = 1'b0; mode = 2'b00; limit = '0; sat = 1'b0;
    endtask

    initial begin
        logic [N-1:0] gray_tbl [16];
        logic [N-1:0] john_tbl [8];
        gray_tbl = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                     4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        john_tbl = '{4'h1, 4'h3, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h0};

        // Binary up, limit 9, wrap: 1..9,0,1,2 with tc only alongside 0.
        for (int i = 1; i <= 12; i++)
            add("bin_up_wrap", 0, 0, 0, 1, 0, 2'b00, 4'd9, 0, N'(i % 10), (i == 10));
        // clr and load together: clr wins, seed of binary.
        add("clr_over_load", 1, 1, 4'hA, 0, 0, 2'b00, 4'd9, 0, 4'h0, 0);
        // Binary down, limit 5, saturate, from st=1.
        add("load_1", 0, 1, 4'h1, 0, 0, 2'b00, 4'd5, 1, 4'h1, 0);
        add("bin_dn_sat", 0, 0, 0, 1, 1, 2'b00, 4'd5, 1, 4'h0, 0);
        for (int i = 0; i < 3; i++)
            add("bin_dn_sat_hold", 0, 0, 0, 1, 1, 2'b00, 4'd5, 1, 4'h0, 1);
        add("hold_no_enable", 0, 0, 0, 0, 1, 2'b00, 4'd5, 1, 4'h0, 0);
        // Down wrap reloads limit.
        add("bin_dn_wrap", 0, 0, 0, 1, 1, 2'b00, 4'd5, 0, 4'h5, 1);
        add("bin_dn_step", 0, 0, 0, 1, 1, 2'b00, 4'd5, 0, 4'h4, 0);
        // limit 0: stays 0 with tc every enabled cycle.
        add("clr_bin", 1, 0, 0, 0, 0, 2'b00, 4'd0, 0, 4'h0, 0);
        add("lim0_a", 0, 0, 0, 1, 0, 2'b00, 4'd0, 0, 4'h0, 1);
        add("lim0_b", 0, 0, 0, 1, 0, 2'b00, 4'd0, 0, 4'h0, 1);
        // Gray: mode change to seed, then 16 up steps with limit 15.
        add("gray_mode_chg", 0, 0, 0, 0, 0, 2'b01, 4'd15, 0, 4'h0, 0);
        for (int i = 1; i <= 16; i++)
            add("gray_up", 0, 0, 0, 1, 0, 2'b01, 4'd15, 0, gray_tbl[i % 16], (i == 16));
        // Ring: switch from binary at count 7, then rotate left.
        add("bin_mode_chg", 0, 0, 0, 0, 0, 2'b00, 4'd9, 0, 4'h0, 0);
        add("load_7", 0, 1, 4'h7, 0, 0, 2'b00, 4'd9, 0, 4'h7, 0);
        add("ring_mode_chg", 0, 0, 0, 0, 0, 2'b11, 4'd9, 0, 4'h1, 0);
        add("ring_l1", 0, 0, 0, 1, 0, 2'b11, 4'd9, 0, 4'h2, 0);
        add("ring_l2", 0, 0, 0, 1, 0, 2'b11, 4'd9, 0, 4'h4, 0);
        add("ring_l3", 0, 0, 0, 1, 0, 2'b11, 4'd9, 0, 4'h8, 0);
        add("ring_l4", 0, 0, 0, 1, 0, 2'b11, 4'd9, 0, 4'h1, 1);
        add("ring_r1", 0, 0, 0, 1, 1, 2'b11, 4'd9, 1, 4'h8, 0);
        // Johnson: mode change wins over enable, then 8 left steps and one right.
        add("john_mode_chg", 0, 0, 0, 1, 0, 2'b10, 4'd9, 0, 4'h0, 0);
        for (int i = 0; i < 8; i++)
            add("john_l", 0, 0, 0, 1, 0, 2'b10, 4'd3, 1, john_tbl[i], (i == 7));
        add("john_r", 0, 0, 0, 1, 1, 2'b10, 4'd3, 1, 4'h8, 0);
        // Load keeps a non-Johnson value unmodified.
        add("john_load_raw", 0, 1, 4'h5, 1, 0, 2'b10, 4'd3, 0, 4'h5, 0);

        drive_idle();
        rst = 1'b1;
        #12;
        check("reset_count", count, '0);
        check("reset_tc", {3'b0, tc}, 4'h0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            clr = vecs[i].clr; load = vecs[i].load; load_val = vecs[i].load_val;
            enable = vecs[i].enable; dir = vecs[i].dir; mode = vecs[i].mode;
            limit = vecs[i].limit; sat = vecs[i].sat;
            @(negedge clk);
            check($sformatf("v%0d %s count", i, vecs[i].tag), count, vecs[i].exp_count);
            check($sformatf("v%0d %s tc", i, vecs[i].tag), {3'b0, tc}, {3'b0, vecs[i].exp_tc});
        end

        // Asynchronous reset mid-count: count goes to 0 before the next edge.
        drive_idle();
        clr = 1'b1; limit = 4'd15;
        @(negedge clk);
        clr = 1'b0; enable = 1'b1;
        repeat (6) @(negedge clk);
        check("midcount_pre_rst", count, 4'h6);
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", count, '0);
        check("async_rst_tc", {3'b0, tc}, 4'h0);
        @(negedge clk);
        check("rst_held_count", count, '0);

        // After reset with ring selected, the first edge loads the ring seed.
        mode = 2'b11; enable = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ring_seed", count, 4'h1);
        check("post_rst_ring_tc", {3'b0, tc}, 4'h0);
        enable = 1'b1;
        @(negedge clk);
        check("post_rst_ring_step", count, 4'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
